// File: rtl/fft_peak_finder.sv
// Streaming FFT peak finder: alpha-max-beta-min magnitude feeding a sorted top-PEAK_NUM table.
// Define FFT_PEAK_MAG_STREAM_EN to add the m_valid/m_mag/m_idx magnitude stream outputs.
module fft_peak_finder #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int PEAK_NUM      = 4,
  parameter int SKIP_BINS     = 1,
  parameter int HALF_SPECTRUM = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          threshold,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic signed [DATA_WIDTH-1:0]   s_real,
  input  logic signed [DATA_WIDTH-1:0]   s_imag,
  input  logic                           s_last,
  output logic                           done,
  output logic                           frame_err,
  output logic [PEAK_NUM-1:0]            peak_valid,
  output logic [PEAK_NUM*ADDR_WIDTH-1:0] peak_idx,
  output logic [PEAK_NUM*DATA_WIDTH-1:0] peak_mag
`ifdef FFT_PEAK_MAG_STREAM_EN
  ,
  output logic                           m_valid,
  output logic [DATA_WIDTH-1:0]          m_mag,
  output logic [ADDR_WIDTH-1:0]          m_idx
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] SKIP_IDX = ADDR_WIDTH'(SKIP_BINS);
  localparam bit                    HALF_EN  = (HALF_SPECTRUM != 0);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic                  hs, cnt_max, end_hs, elig;
  logic [ADDR_WIDTH-1:0] bin_cnt;
  logic [1:0]            flush_cnt;
  logic [DATA_WIDTH-1:0] thr_q;
  logic                  err_q;

  logic                  s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0] s1_a, s1_b, s2_mag;
  logic [ADDR_WIDTH-1:0] s1_idx, s2_idx;
  logic [DATA_WIDTH-1:0] mx, mn, sum, mag;

  logic [PEAK_NUM-1:0]   tbl_valid, ins_valid, gt;
  logic [DATA_WIDTH-1:0] tbl_mag [PEAK_NUM];
  logic [DATA_WIDTH-1:0] ins_mag [PEAK_NUM];
  logic [ADDR_WIDTH-1:0] tbl_idx [PEAK_NUM];
  logic [ADDR_WIDTH-1:0] ins_idx [PEAK_NUM];

  function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] v);
    if (!v[DATA_WIDTH-1])  abs_sat = v;
    else if (v == MOST_NEG) abs_sat = MOST_POS;
    else                   abs_sat = ~v + 1'b1;
  endfunction

  // Handshake: a bin transfers on a cycle where s_valid && s_ready; s_ready is high
  // exactly in RUN and never depends on s_valid.
  assign s_ready = (state == RUN);
  assign hs      = s_valid && s_ready;
  assign cnt_max = (bin_cnt == LAST_IDX);
  assign end_hs  = hs && (s_last || cnt_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (end_hs) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == 2'd2) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = RUN;
  end

  // a and b never exceed MOST_POS, so 2*mn and the shifted sum fit in DATA_WIDTH.
  always_comb begin
    mx  = (s1_a >= s1_b) ? s1_a : s1_b;
    mn  = (s1_a >= s1_b) ? s1_b : s1_a;
    sum = {1'b0, s1_a[DATA_WIDTH-1:1]} + {2'b00, s1_a[DATA_WIDTH-1:2]} +
          {1'b0, s1_b[DATA_WIDTH-1:1]} + {2'b00, s1_b[DATA_WIDTH-1:2]};
    mag = (mx >= (mn << 1)) ? mx : sum;
  end

  assign elig = s2_valid && (s2_idx >= SKIP_IDX) &&
                (!HALF_EN || !s2_idx[ADDR_WIDTH-1]) && (s2_mag > thr_q);

  // Table stays sorted with empty slots at the tail, so gt[] is a thermometer code.
  always_comb begin
    gt = '0;
    for (int k = 0; k < PEAK_NUM; k++) begin
      gt[k]        = !tbl_valid[k] || (s2_mag > tbl_mag[k]);
      ins_valid[k] = tbl_valid[k];
      ins_mag[k]   = tbl_mag[k];
      ins_idx[k]   = tbl_idx[k];
    end
    if (gt[0]) begin
      ins_valid[0] = 1'b1;
      ins_mag[0]   = s2_mag;
      ins_idx[0]   = s2_idx;
    end
    for (int k = 1; k < PEAK_NUM; k++) begin
      if (gt[k-1]) begin
        ins_valid[k] = tbl_valid[k-1];
        ins_mag[k]   = tbl_mag[k-1];
        ins_idx[k]   = tbl_idx[k-1];
      end else if (gt[k]) begin
        ins_valid[k] = 1'b1;
        ins_mag[k]   = s2_mag;
        ins_idx[k]   = s2_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt    <= '0;
      flush_cnt  <= '0;
      thr_q      <= '0;
      err_q      <= 1'b0;
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_idx     <= '0;
      s2_valid   <= 1'b0;
      s2_mag     <= '0;
      s2_idx     <= '0;
      tbl_valid  <= '0;
      for (int k = 0; k < PEAK_NUM; k++) begin
        tbl_mag[k] <= '0;
        tbl_idx[k] <= '0;
      end
      done       <= 1'b0;
      frame_err  <= 1'b0;
      peak_valid <= '0;
      peak_idx   <= '0;
      peak_mag   <= '0;
    end else begin
      s1_valid  <= hs && !start;
      if (hs) begin
        s1_a   <= abs_sat(s_real);
        s1_b   <= abs_sat(s_imag);
        s1_idx <= bin_cnt;
      end
      s2_valid  <= s1_valid && !start;
      s2_mag    <= mag;
      s2_idx    <= s1_idx;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      if (start) begin
        bin_cnt   <= '0;
        thr_q     <= threshold;
        err_q     <= 1'b0;
        tbl_valid <= '0;
        for (int k = 0; k < PEAK_NUM; k++) begin
          tbl_mag[k] <= '0;
          tbl_idx[k] <= '0;
        end
      end else begin
        if (hs)     bin_cnt <= bin_cnt + ADDR_WIDTH'(1);
        if (end_hs) err_q   <= s_last ^ cnt_max;
        if (elig) begin
          tbl_valid <= ins_valid;
          for (int k = 0; k < PEAK_NUM; k++) begin
            tbl_mag[k] <= ins_mag[k];
            tbl_idx[k] <= ins_idx[k];
          end
        end
      end
      // Results publish on entry to DONE, so done and the new table appear together.
      if (state == FLUSH && state_nxt == DONE) begin
        done       <= 1'b1;
        frame_err  <= err_q;
        peak_valid <= tbl_valid;
        for (int k = 0; k < PEAK_NUM; k++) begin
          peak_idx[k*ADDR_WIDTH +: ADDR_WIDTH] <= tbl_idx[k];
          peak_mag[k*DATA_WIDTH +: DATA_WIDTH] <= tbl_mag[k];
        end
      end
    end
  end

`ifdef FFT_PEAK_MAG_STREAM_EN
  assign m_valid = s2_valid;
  assign m_mag   = s2_mag;
  assign m_idx   = s2_idx;
`endif

endmodule

// File: tb/tb_fft_peak_finder.sv
// Self-checking bench for fft_peak_finder: directed scenarios plus random frames
// checked against a sort-based reference model of the peak table.
module tb_fft_peak_finder;
  localparam int DW = 16, AW = 8, PN = 4, SKIP = 1, HALF_LIM = 128;
  localparam int EW = 1 + AW + DW;

  logic                 clk = 1'b0;
  logic                 rst, start, s_valid, s_ready, s_last, done, frame_err;
  logic [DW-1:0]        threshold;
  logic signed [DW-1:0] s_real, s_imag;
  logic [PN-1:0]        peak_valid;
  logic [PN*AW-1:0]     peak_idx;
  logic [PN*DW-1:0]     peak_mag;
`ifdef FFT_PEAK_MAG_STREAM_EN
  logic                 m_valid;
  logic [DW-1:0]        m_mag;
  logic [AW-1:0]        m_idx;
`endif

  int n_cmp = 0, n_fail = 0;
  int re_a[256], im_a[256];
  logic [EW-1:0] exp_q[$];
  logic [PN-1:0]    exp_pv, cur_pv;
  logic [PN*AW-1:0] exp_pi, cur_pi;
  logic [PN*DW-1:0] exp_pm, cur_pm;
  logic             exp_err;

  fft_peak_finder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PEAK_NUM(PN),
                    .SKIP_BINS(SKIP), .HALF_SPECTRUM(1)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .s_last(s_last), .done(done), .frame_err(frame_err),
    .peak_valid(peak_valid), .peak_idx(peak_idx), .peak_mag(peak_mag)
`ifdef FFT_PEAK_MAG_STREAM_EN
    , .m_valid(m_valid), .m_mag(m_mag), .m_idx(m_idx)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // reference model
  function automatic int ref_mag(input int re, input int im);
    int a, b, hi, lo;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    if (hi >= 2 * lo) return hi;
    return a / 2 + a / 4 + b / 2 + b / 4;
  endfunction

  task automatic build_expected(input int n, input int thr);
    int mags[$], idxs[$];
    bit used[$];
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      int m;
      m = ref_mag(re_a[i], im_a[i]);
      if (i >= SKIP && i < HALF_LIM && m > thr) begin
        mags.push_back(m);
        idxs.push_back(i);
        used.push_back(1'b0);
      end
    end
    for (int k = 0; k < PN; k++) begin
      int best;
      best = -1;
      for (int j = 0; j < mags.size(); j++)
        if (!used[j] && (best < 0 || mags[j] > mags[best])) best = j;
      if (best >= 0) begin
        used[best] = 1'b1;
        exp_q.push_back({1'b1, AW'(idxs[best]), DW'(mags[best])});
      end else begin
        exp_q.push_back('0);
      end
    end
  endtask

  task automatic pop_expected();
    logic [EW-1:0] e;
    exp_pv = '0; exp_pi = '0; exp_pm = '0;
    for (int k = 0; k < PN; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      exp_pv[k]            = e[EW-1];
      exp_pi[k*AW +: AW]   = e[DW +: AW];
      exp_pm[k*DW +: DW]   = e[DW-1:0];
    end
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 5))
      0:       return -32768;
      1:       return 300;
      2:       return -1000;
      3:       return 0;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic clear_bins();
    for (int i = 0; i < 256; i++) begin re_a[i] = 0; im_a[i] = 0; end
  endtask

  task automatic fill_random(input int density);
    clear_bins();
    for (int i = 0; i < 256; i++)
      if ($urandom_range(0, density) == 0) begin re_a[i] = rand_val(); im_a[i] = rand_val(); end
  endtask

  // drivers (all input changes on the falling edge)
  task automatic start_frame(input int thr);
    threshold = DW'(thr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run_ready", 64'(s_ready), 64'd1);
  endtask

  task automatic drive_bins(input int n, input bit use_last, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) begin s_valid = 1'b0; @(negedge clk); end
      s_valid = 1'b1;
      s_real  = DW'(re_a[i]);
      s_imag  = DW'(im_a[i]);
      s_last  = use_last && (i == n - 1);
      check("bin_ready", 64'(s_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_frame();
    for (int c = 0; c < 3; c++) begin
      check("flush_done", 64'(done), 64'd0);
      check("flush_ready", 64'(s_ready), 64'd0);
      check("hold_valid", 64'(peak_valid), 64'(cur_pv));
      check("hold_idx", 64'(peak_idx), 64'(cur_pi));
      check("hold_mag", 64'(peak_mag), 64'(cur_pm));
      @(negedge clk);
    end
    pop_expected();
    check("done_pulse", 64'(done), 64'd1);
    check("frame_err", 64'(frame_err), 64'(exp_err));
    check("peak_valid", 64'(peak_valid), 64'(exp_pv));
    check("peak_idx", 64'(peak_idx), 64'(exp_pi));
    check("peak_mag", 64'(peak_mag), 64'(exp_pm));
    cur_pv = exp_pv; cur_pi = exp_pi; cur_pm = exp_pm;
    @(negedge clk);
    check("done_low", 64'(done), 64'd0);
    check("err_low", 64'(frame_err), 64'd0);
    check("idle_ready", 64'(s_ready), 64'd0);
    check("keep_valid", 64'(peak_valid), 64'(cur_pv));
  endtask

  task automatic send_frame(input int n, input bit use_last, input bit gap, input int thr);
    start_frame(thr);
    build_expected(n, thr);
    exp_err = use_last ^ (n == 256);
    drive_bins(n, use_last, gap);
    finish_frame();
  endtask

  task automatic scenario_one();
    clear_bins();
    re_a[10] = 300;
    im_a[20] = -500;
    re_a[30] = 200; im_a[30] = 200;
  endtask

  initial begin
    int n;
    bit ul;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_real = '0; s_imag = '0; threshold = '0;
    cur_pv = '0; cur_pi = '0; cur_pm = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(peak_valid), 64'd0);
    check("rst_idx", 64'(peak_idx), 64'd0);
    check("rst_mag", 64'(peak_mag), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    scenario_one();
    send_frame(256, 1'b1, 1'b0, 0);
    check("s1_valid_const", 64'(peak_valid), 64'b0111);
    check("s1_idx_const", 64'(peak_idx), {32'd0, 8'd0, 8'd30, 8'd10, 8'd20});

    clear_bins();
    re_a[0] = 4000; re_a[200] = 5000; re_a[5] = 100;
    send_frame(256, 1'b1, 1'b0, 0);
    check("dc_half_valid", 64'(peak_valid), 64'b0001);

    fill_random(6);
    send_frame(100, 1'b1, 1'b0, 0);

    clear_bins();
    re_a[3] = -32768; re_a[4] = 1000; im_a[4] = 800; im_a[7] = -32768;
    send_frame(256, 1'b1, 1'b0, 0);
    check("sat_mag", 64'(peak_mag[DW-1:0]), 64'd32767);
    check("ambm_mag", 64'(peak_mag[2*DW +: DW]), 64'd1350);

    fill_random(3);
    start_frame(0);
    drive_bins(50, 1'b0, 1'b0);
    check("abort_valid", 64'(peak_valid), 64'(cur_pv));
    check("abort_idx", 64'(peak_idx), 64'(cur_pi));
    check("abort_mag", 64'(peak_mag), 64'(cur_pm));
    fill_random(5);
    send_frame(256, 1'b1, 1'b0, 0);

    for (int r = 0; r < 5; r++) begin
      fill_random(int'($urandom_range(2, 10)));
      n  = ($urandom_range(0, 1) == 1) ? 256 : int'($urandom_range(2, 255));
      ul = (n < 256) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(n, ul, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3000)));
    end

    scenario_one();
    send_frame(256, 1'b1, 1'b0, 300);
    check("thr_strict_valid", 64'(peak_valid), 64'b0001);

    scenario_one();
    send_frame(256, 1'b1, 1'b1, 250);
    check("thr250_valid", 64'(peak_valid), 64'b0111);

    scenario_one();
    start_frame(0);
    drive_bins(20, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(peak_valid), 64'd0);
    check("mid_rst_idx", 64'(peak_idx), 64'd0);
    check("mid_rst_mag", 64'(peak_mag), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_err", 64'(frame_err), 64'd0);
    check("mid_rst_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
